// File: rtl/vram_blitter.sv
// Port-mapped video RAM fill/copy engine: the CPU programs an 8-byte register
// window, then this block drives the video RAM CPU-side port until the run completes.
module vram_blitter #(
    parameter logic [15:0] BASE_PORT = 16'h0040,
    parameter int          ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       port_add,
    input  logic [7:0]        port_data_in,
    input  logic              port_we,
    output logic [7:0]        port_data_out,
    output logic [ADDR_W-1:0] vram_add,
    output logic [7:0]        vram_out,
    input  logic [7:0]        vram_in,
    output logic              vram_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FILL, CP_RD, CP_WR} state_t;

    state_t state, state_n;

    logic [14:0]       dst_reg, src_reg, len_reg;
    logic [7:0]        fill_reg;
    logic              we_q;
    logic              done_flag, done_flag_n, done_n;
    logic [ADDR_W-1:0] dst_w, dst_n, src_w, src_n;
    logic [14:0]       len_w, len_n;

    logic [15:0] off;
    logic        in_win, wr_edge, cfg_wr, ctrl_wr, start, abort;

    // Offset arithmetic keeps the window check correct for any BASE_PORT alignment.
    assign off     = port_add - BASE_PORT;
    assign in_win  = (off[15:3] == '0);
    assign wr_edge = port_we & ~we_q & in_win;
    assign cfg_wr  = wr_edge & ~busy & (off[2:0] != 3'd5);
    assign ctrl_wr = wr_edge & (off[2:0] == 3'd5);
    assign start   = ctrl_wr & port_data_in[0] & ~port_data_in[7] & ~busy;
    assign abort   = ctrl_wr & port_data_in[7] & busy;
    assign busy    = (state != IDLE);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            dst_reg  <= '0;
            src_reg  <= '0;
            len_reg  <= '0;
            fill_reg <= '0;
            we_q     <= 1'b0;
        end else begin
            we_q <= port_we;
            if (cfg_wr) begin
                case (off[2:0])
                    3'd0:    dst_reg[7:0]  <= port_data_in;
                    3'd1:    dst_reg[14:8] <= port_data_in[6:0];
                    3'd2:    len_reg[7:0]  <= port_data_in;
                    3'd3:    len_reg[14:8] <= port_data_in[6:0];
                    3'd4:    fill_reg      <= port_data_in;
                    3'd6:    src_reg[7:0]  <= port_data_in;
                    3'd7:    src_reg[14:8] <= port_data_in[6:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        port_data_out = 8'h00;
        if (in_win) begin
            case (off[2:0])
                3'd0:    port_data_out = dst_reg[7:0];
                3'd1:    port_data_out = {1'b0, dst_reg[14:8]};
                3'd2:    port_data_out = len_reg[7:0];
                3'd3:    port_data_out = {1'b0, len_reg[14:8]};
                3'd4:    port_data_out = fill_reg;
                3'd5:    port_data_out = {6'b0, done_flag, busy};
                3'd6:    port_data_out = src_reg[7:0];
                default: port_data_out = {1'b0, src_reg[14:8]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dst_w     <= '0;
            src_w     <= '0;
            len_w     <= '0;
            done      <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            state     <= state_n;
            dst_w     <= dst_n;
            src_w     <= src_n;
            len_w     <= len_n;
            done      <= done_n;
            done_flag <= done_flag_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n     = state;
        dst_n       = dst_w;
        src_n       = src_w;
        len_n       = len_w;
        done_n      = 1'b0;
        done_flag_n = done_flag;
        vram_we     = 1'b0;
        vram_add    = '0;
        vram_out    = 8'h00;

        case (state)
            IDLE: begin
                if (start) begin
                    done_flag_n = 1'b0;
                    dst_n       = dst_reg[ADDR_W-1:0];
                    src_n       = src_reg[ADDR_W-1:0];
                    len_n       = len_reg;
                    if (len_reg == '0) begin
                        done_n      = 1'b1;
                        done_flag_n = 1'b1;
                    end else begin
                        state_n = port_data_in[1] ? CP_RD : FILL;
                    end
                end
            end
            FILL: begin
                vram_we  = 1'b1;
                vram_add = dst_w;
                vram_out = fill_reg;
                dst_n    = dst_w + ADDR_W'(1);
                len_n    = len_w - 15'd1;
                if (len_w == 15'd1) begin
                    state_n     = IDLE;
                    done_n      = 1'b1;
                    done_flag_n = 1'b1;
                end
            end
            CP_RD: begin
                vram_add = src_w;
                state_n  = CP_WR;
            end
            default: begin
                // vram_in now holds the byte addressed during the preceding CP_RD cycle.
                vram_we  = 1'b1;
                vram_add = dst_w;
                vram_out = vram_in;
                src_n    = src_w + ADDR_W'(1);
                dst_n    = dst_w + ADDR_W'(1);
                len_n    = len_w - 15'd1;
                if (len_w == 15'd1) begin
                    state_n     = IDLE;
                    done_n      = 1'b1;
                    done_flag_n = 1'b1;
                end else begin
                    state_n = CP_RD;
                end
            end
        endcase

        // The write issued in the abort cycle still lands; nothing follows it.
        if (abort) begin
            state_n     = IDLE;
            done_n      = 1'b0;
            done_flag_n = done_flag;
        end
    end

endmodule

// File: tb/tb_vram_blitter.sv
// Directed bench for vram_blitter: a dual-port RAM model records every write,
// and expected write streams queued by the stimulus are compared after each run.
module tb_vram_blitter;

    localparam logic [15:0] BASE = 16'h0040;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] port_add;
    logic [7:0]  port_data_in;
    logic        port_we;
    logic [7:0]  port_data_out;
    logic [14:0] vram_add;
    logic [7:0]  vram_out;
    logic [7:0]  vram_in;
    logic        vram_we;
    logic        busy;
    logic        done;

    always #10 clk = ~clk;

    vram_blitter #(.BASE_PORT(BASE), .ADDR_W(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .port_add     (port_add),
        .port_data_in (port_data_in),
        .port_we      (port_we),
        .port_data_out(port_data_out),
        .vram_add     (vram_add),
        .vram_out     (vram_out),
        .vram_in      (vram_in),
        .vram_we      (vram_we),
        .busy         (busy),
        .done         (done)
    );

    // Video RAM model with a side preload port driven only by the stimulus.
    logic [7:0]  mem [0:32767];
    logic        pre_we;
    logic [14:0] pre_a;
    logic [7:0]  pre_d;

    always @(posedge clk) begin
        if (vram_we) mem[vram_add] <= vram_out;
        else if (pre_we) mem[pre_a] <= pre_d;
        vram_in <= mem[vram_add];
    end

    logic [22:0] obs_q[$];
    int we_cnt = 0, busy_cnt = 0, done_cnt = 0, we_idle_cnt = 0;

    always @(negedge clk) begin
        if (vram_we) begin
            obs_q.push_back({vram_add, vram_out});
            we_cnt <= we_cnt + 1;
            if (!busy) we_idle_cnt <= we_idle_cnt + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int          tests = 0;
    int          fails = 0;
    int          obs_rd = 0;
    logic [22:0] exp_q[$];
    int          w0, b0, d0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic port_wr(input logic [2:0] o, input logic [7:0] d);
        port_add     = BASE + 16'(o);
        port_data_in = d;
        port_we      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        port_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        port_add = a;
        #1;
        check(tag, 32'(port_data_out), 32'(exp));
    endtask

    task automatic push_exp(input logic [14:0] a, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({a + 15'(i), d});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_timeout"}, 32'(busy), 32'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_rd < obs_q.size()) begin
                check(tag, 32'(obs_q[obs_rd]), 32'(exp_q[i]));
                obs_rd++;
            end
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic snap();
        w0 = we_cnt;
        b0 = busy_cnt;
        d0 = done_cnt;
    endtask

    initial begin
        reset        = 1'b1;
        port_add     = 16'h0000;
        port_data_in = 8'h00;
        port_we      = 1'b0;
        pre_we       = 1'b0;
        pre_a        = '0;
        pre_d        = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and readback
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_we", 32'(vram_we), 32'(0));
        check("rst_add", 32'(vram_add), 32'(0));
        check("rst_out", 32'(vram_out), 32'(0));
        for (int i = 0; i < 8; i++) check_rd($sformatf("rst_rd%0d", i), BASE + 16'(i), 8'h00);
        check_rd("out_of_window", BASE + 16'd8, 8'h00);

        // Fill 4 bytes at 0x1000
        port_wr(3'd0, 8'h00);
        port_wr(3'd1, 8'h10);
        port_wr(3'd2, 8'h04);
        port_wr(3'd3, 8'h00);
        port_wr(3'd4, 8'hA5);
        check_rd("rd_dst_h", BASE + 16'd1, 8'h10);
        check_rd("rd_len_l", BASE + 16'd2, 8'h04);
        check_rd("rd_fill", BASE + 16'd4, 8'hA5);
        push_exp(15'h1000, 8'hA5, 4);
        snap();
        port_wr(3'd5, 8'h01);
        wait_idle("fill4");
        drain("fill4_wr");
        check("fill4_we_cycles", 32'(we_cnt - w0), 32'(4));
        check("fill4_busy_cycles", 32'(busy_cnt - b0), 32'(4));
        check("fill4_done", 32'(done_cnt - d0), 32'(1));
        check_rd("fill4_ctrl", BASE + 16'd5, 8'h02);

        // Fill wrapping past the top of video RAM
        port_wr(3'd0, 8'hFE);
        port_wr(3'd1, 8'h7F);
        port_wr(3'd2, 8'h03);
        push_exp(15'h7FFE, 8'hA5, 3);
        snap();
        port_wr(3'd5, 8'h01);
        wait_idle("wrap");
        drain("wrap_wr");
        check("wrap_done", 32'(done_cnt - d0), 32'(1));

        // Copy 3 bytes 0x0100 -> 0x2000
        pre_we = 1'b1;
        pre_a = 15'h0100; pre_d = 8'h11; @(posedge clk); #1;
        pre_a = 15'h0101; pre_d = 8'h22; @(posedge clk); #1;
        pre_a = 15'h0102; pre_d = 8'h33; @(posedge clk); #1;
        pre_we = 1'b0;
        port_wr(3'd6, 8'h00);
        port_wr(3'd7, 8'h01);
        port_wr(3'd0, 8'h00);
        port_wr(3'd1, 8'h20);
        check_rd("rd_src_h", BASE + 16'd7, 8'h01);
        exp_q.push_back({15'h2000, 8'h11});
        exp_q.push_back({15'h2001, 8'h22});
        exp_q.push_back({15'h2002, 8'h33});
        snap();
        port_wr(3'd5, 8'h03);
        wait_idle("copy");
        drain("copy_wr");
        check("copy_busy_cycles", 32'(busy_cnt - b0), 32'(6));
        check("copy_done", 32'(done_cnt - d0), 32'(1));
        check("copy_mem2", 32'(mem[15'h2002]), 32'(8'h33));

        // Abort a long fill after 10 writes
        port_wr(3'd0, 8'h00);
        port_wr(3'd1, 8'h30);
        port_wr(3'd2, 8'd100);
        push_exp(15'h3000, 8'hA5, 10);
        snap();
        port_wr(3'd5, 8'h01);
        for (int n = 0; n < 200 && (we_cnt - w0) != 9; n++) begin
            @(posedge clk);
            #1;
        end
        check("abort_reach9", 32'(we_cnt - w0), 32'(9));
        port_add     = BASE + 16'd5;
        port_data_in = 8'h80;
        port_we      = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy_drop", 32'(busy), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        port_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drain("abort_wr");
        check("abort_we_cycles", 32'(we_cnt - w0), 32'(10));
        check("abort_no_done", 32'(done_cnt - d0), 32'(0));
        check_rd("abort_ctrl", BASE + 16'd5, 8'h00);

        // Zero-length start
        port_wr(3'd2, 8'h00);
        snap();
        port_wr(3'd5, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        check("len0_we", 32'(we_cnt - w0), 32'(0));
        check("len0_busy", 32'(busy_cnt - b0), 32'(0));
        check("len0_done", 32'(done_cnt - d0), 32'(1));
        check_rd("len0_ctrl", BASE + 16'd5, 8'h02);

        // Register and start writes while busy are ignored
        port_wr(3'd1, 8'h40);
        port_wr(3'd2, 8'd40);
        push_exp(15'h4000, 8'hA5, 40);
        snap();
        port_wr(3'd5, 8'h01);
        port_wr(3'd0, 8'h55);
        port_wr(3'd5, 8'h01);
        check("busy_still", 32'(busy), 32'(1));
        wait_idle("ignore");
        drain("ignore_wr");
        check("ignore_we_cycles", 32'(we_cnt - w0), 32'(40));
        check("ignore_done", 32'(done_cnt - d0), 32'(1));
        check_rd("ignore_dst_l", BASE + 16'd0, 8'h00);
        check_rd("ignore_dst_h", BASE + 16'd1, 8'h40);
        check("we_while_idle", 32'(we_idle_cnt), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
